t5_fetch: RTL and testbench

Instruction fetch unit for the t5 pipeline. It is the Wishbone initiator on the instruction bus: it owns the fetch PC, issues classic-cycle reads, and buffers returned words in a 2-entry queue. It presents each queued word with its PC to the decode stage, which consumes it under `sena`. It also accepts a redirect from the execute stage: a taken branch, jump or trap. On a redirect it flushes the queue and discards any in-flight response.

---
 rtl/t5_fetch.sv | 189 ++++++++++++++++++
 tb/tb_t5_fetch.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/t5_fetch.sv
// t5_fetch: instruction fetch unit for the t5 pipeline.
//
// Acts as the Wishbone classic-cycle initiator on the instruction bus. It owns
// the fetch PC, issues word reads, and buffers returned words in a 2-entry
// queue. The decode stage sees the queue head and consumes it under sena. A
// redirect from execute (branch/jump/trap) flushes the queue and discards any
// response still in flight.
//
// Ports
//   sclk, srst_n      clock, asynchronous active-low reset
//   sena              decode consumes the head entry on this edge
//   sbra, bpc         redirect request and target (bpc[1:0] ignored)
//   iwb_adr/stb/cyc   Wishbone address, strobe, cycle (cyc == stb)
//   iwb_sel, iwb_we   constant 4'hF and 0 (word reads only)
//   iwb_ack, iwb_dat  slave acknowledge and read data
//   fpc, fins, fvld   registered head entry PC, word and valid
//
// Bus FSM
//   state | meaning
//   IDLE  | no request on the bus; waiting for queue room
//   REQ   | read of rpc outstanding; ack pushes into the queue
//   DROP  | read outstanding for a stale address; ack is discarded

module t5_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        sclk,
  input  logic        srst_n,
  input  logic        sena,
  input  logic        sbra,
  input  logic [31:0] bpc,
  output logic [31:0] iwb_adr,
  output logic        iwb_stb,
  output logic        iwb_cyc,
  output logic [3:0]  iwb_sel,
  output logic        iwb_we,
  input  logic        iwb_ack,
  input  logic [31:0] iwb_dat,
  output logic [31:0] fpc,
  output logic [31:0] fins,
  output logic        fvld
);

  localparam logic [31:0] RESET_WPC = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] rpc_q, rpc_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] pc0_q, pc0_d, ins0_q, ins0_d;
  logic [31:0] pc1_q, pc1_d, ins1_q, ins1_d;
  logic [1:0]  occ_q, occ_d;

  logic [31:0] tgt;
  logic        push;
  logic        pop;
  logic        can_issue;
  logic        bpc_unused;

  assign bpc_unused = ^bpc[1:0];

  always_comb begin
    state_d = state_q;
    rpc_d   = rpc_q;
    adr_d   = adr_q;
    pc0_d   = pc0_q;
    ins0_d  = ins0_q;
    pc1_d   = pc1_q;
    ins1_d  = ins1_q;
    occ_d   = occ_q;

    tgt  = {bpc[31:2], 2'b00};
    // In REQ the bus address always equals rpc, so rpc_q tags the pushed word.
    push = (state_q == ST_REQ) && iwb_ack && !sbra;
    pop  = sena && (occ_q != 2'd0) && !sbra;

    // Entry 0 is the head and drives fpc/fins directly. It is never cleared on
    // a pop or flush, so the head outputs hold their last values when empty.
    if (sbra) begin
      occ_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b11: begin
          if (occ_q == 2'd1) begin
            pc0_d  = rpc_q;
            ins0_d = iwb_dat;
          end else begin
            pc0_d  = pc1_q;
            ins0_d = ins1_q;
            pc1_d  = rpc_q;
            ins1_d = iwb_dat;
          end
        end
        2'b10: begin
          if (occ_q == 2'd0) begin
            pc0_d  = rpc_q;
            ins0_d = iwb_dat;
          end else begin
            pc1_d  = rpc_q;
            ins1_d = iwb_dat;
          end
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          if (occ_q == 2'd2) begin
            pc0_d  = pc1_q;
            ins0_d = ins1_q;
          end
          occ_d = occ_q - 2'd1;
        end
        default: ;
      endcase
    end

    // Room for one more word once this edge's push/pop has settled, so an ack
    // can never land on a full queue.
    can_issue = (occ_d <= 2'd1);

    case (state_q)
      ST_IDLE: begin
        if (sbra) begin
          rpc_d   = tgt;
          state_d = ST_REQ;
        end else if (can_issue) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sbra) begin
          rpc_d   = tgt;
          state_d = iwb_ack ? ST_REQ : ST_DROP;
        end else if (iwb_ack) begin
          rpc_d   = rpc_q + 32'd4;
          state_d = can_issue ? ST_REQ : ST_IDLE;
        end
      end
      ST_DROP: begin
        // Later redirects only retarget rpc; the stale read must still finish.
        if (sbra) begin
          rpc_d = tgt;
        end
        if (iwb_ack) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The bus address tracks rpc except while a stale read is being drained.
    adr_d = (state_d == ST_DROP) ? adr_q : rpc_d;
  end

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      state_q <= ST_IDLE;
      rpc_q   <= RESET_WPC;
      adr_q   <= RESET_WPC;
      pc0_q   <= 32'd0;
      ins0_q  <= 32'd0;
      pc1_q   <= 32'd0;
      ins1_q  <= 32'd0;
      occ_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      rpc_q   <= rpc_d;
      adr_q   <= adr_d;
      pc0_q   <= pc0_d;
      ins0_q  <= ins0_d;
      pc1_q   <= pc1_d;
      ins1_q  <= ins1_d;
      occ_q   <= occ_d;
    end
  end

  assign iwb_adr = adr_q;
  assign iwb_stb = (state_q != ST_IDLE);
  assign iwb_cyc = iwb_stb;
  assign iwb_sel = 4'hF;
  assign iwb_we  = 1'b0;
  assign fpc     = pc0_q;
  assign fins    = ins0_q;
  assign fvld    = (occ_q != 2'd0);

endmodule

// File: tb/tb_t5_fetch.sv
module tb_t5_fetch;

  logic        sclk = 1'b0;
  logic        srst_n = 1'b1;
  logic        sena = 1'b0;
  logic        sbra = 1'b0;
  logic [31:0] bpc = 32'd0;
  logic        iwb_ack = 1'b0;
  logic [31:0] iwb_dat = 32'd0;
  logic [31:0] iwb_adr;
  logic        iwb_stb;
  logic        iwb_cyc;
  logic [3:0]  iwb_sel;
  logic        iwb_we;
  logic [31:0] fpc;
  logic [31:0] fins;
  logic        fvld;

  always #5 sclk = ~sclk;

  t5_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .sclk    (sclk),
    .srst_n  (srst_n),
    .sena    (sena),
    .sbra    (sbra),
    .bpc     (bpc),
    .iwb_adr (iwb_adr),
    .iwb_stb (iwb_stb),
    .iwb_cyc (iwb_cyc),
    .iwb_sel (iwb_sel),
    .iwb_we  (iwb_we),
    .iwb_ack (iwb_ack),
    .iwb_dat (iwb_dat),
    .fpc     (fpc),
    .fins    (fins),
    .fvld    (fvld)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of {pc, word}, a request PC, and whether a read
  // is outstanding (and whether its data is to be thrown away).
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        mq[$];
  logic        m_busy;
  logic        m_drop;
  logic [31:0] m_rpc;
  logic [31:0] m_adr;
  logic [31:0] m_hpc;
  logic [31:0] m_hins;

  int nwait = 0;
  int wcnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_busy = 1'b0;
    m_drop = 1'b0;
    m_rpc  = 32'h100;
    m_adr  = 32'h100;
    mq.delete();
    m_hpc  = 32'd0;
    m_hins = 32'd0;
    wcnt   = 0;
  endfunction

  function automatic void model_edge();
    logic acked;
    acked = m_busy && iwb_ack;
    if (sbra) begin
      mq.delete();
      m_rpc = {bpc[31:2], 2'b00};
      if (m_busy && !iwb_ack) begin
        m_drop = 1'b1;
      end else begin
        m_busy = 1'b1;
        m_drop = 1'b0;
        m_adr  = m_rpc;
      end
    end else begin
      if (sena && mq.size() > 0) void'(mq.pop_front());
      if (acked && !m_drop) begin
        mq.push_back({m_adr, iwb_dat});
        m_rpc = m_rpc + 32'd4;
      end
      if (!(m_busy && !iwb_ack)) begin
        if (acked && m_drop) begin
          m_drop = 1'b0;
          m_adr  = m_rpc;
        end else begin
          m_busy = (mq.size() < 2);
          m_adr  = m_rpc;
        end
      end
    end
    if (mq.size() > 0) begin
      m_hpc  = mq[0].pc;
      m_hins = mq[0].ins;
    end
  endfunction

  task automatic compare_all();
    chk("stb", iwb_stb, m_busy);
    chk("cyc", iwb_cyc, m_busy);
    chk("sel", iwb_sel, 4'hF);
    chk("we", iwb_we, 1'b0);
    if (m_busy) chk("adr", iwb_adr, m_adr);
    chk("fvld", fvld, mq.size() > 0);
    chk("fpc", fpc, m_hpc);
    chk("fins", fins, m_hins);
  endtask

  // Slave with nwait wait states per transfer, responding to the DUT strobe.
  function automatic void drive_slave();
    iwb_dat = $urandom;
    if (iwb_stb && wcnt >= nwait) begin
      iwb_ack = 1'b1;
      wcnt    = 0;
    end else begin
      iwb_ack = 1'b0;
      if (iwb_stb) wcnt++;
    end
  endfunction

  task automatic step(input logic s_ena, input logic s_bra, input logic [31:0] s_bpc);
    sena = s_ena;
    sbra = s_bra;
    bpc  = s_bpc;
    drive_slave();
    @(posedge sclk);
    model_edge();
    #1;
    compare_all();
    sbra = 1'b0;
  endtask

  task automatic do_reset();
    srst_n  = 1'b0;
    sena    = 1'b0;
    sbra    = 1'b0;
    bpc     = 32'd0;
    iwb_ack = 1'b0;
    repeat (2) @(posedge sclk);
    #1;
    model_reset();
    chk("rst_stb", iwb_stb, 1'b0);
    chk("rst_cyc", iwb_cyc, 1'b0);
    chk("rst_adr", iwb_adr, 32'h100);
    chk("rst_fvld", fvld, 1'b0);
    chk("rst_fpc", fpc, 32'd0);
    chk("rst_fins", fins, 32'd0);
    srst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] tgt;
    int          n;
    logic        found;

    #2;
    // Reset and zero-wait streaming.
    do_reset();
    nwait = 0;
    step(1'b1, 1'b0, 32'd0);
    chk("s1_stb0", iwb_stb, 1'b1);
    chk("s1_adr0", iwb_adr, 32'h100);
    step(1'b1, 1'b0, 32'd0);
    chk("s1_adr1", iwb_adr, 32'h104);
    chk("s1_fpc0", fpc, 32'h100);
    chk("s1_fins0", fins, iwb_dat);
    step(1'b1, 1'b0, 32'd0);
    chk("s1_adr2", iwb_adr, 32'h108);
    chk("s1_fpc1", fpc, 32'h104);
    chk("s1_fins1", fins, iwb_dat);

    // Stall with a zero-wait slave.
    do_reset();
    nwait = 0;
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    chk("s2_stb_full", iwb_stb, 1'b0);
    chk("s2_fpc_frozen", fpc, 32'h100);
    repeat (3) step(1'b0, 1'b0, 32'd0);
    chk("s2_stb_hold", iwb_stb, 1'b0);
    chk("s2_fpc_hold", fpc, 32'h100);
    step(1'b1, 1'b0, 32'd0);
    chk("s2_fpc_next", fpc, 32'h104);
    chk("s2_stb_resume", iwb_stb, 1'b1);
    chk("s2_adr_resume", iwb_adr, 32'h108);
    step(1'b1, 1'b0, 32'd0);
    chk("s2_fpc_108", fpc, 32'h108);

    // Redirect during a wait-stated transfer.
    do_reset();
    nwait = 3;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (iwb_stb && iwb_adr == 32'h104 && wcnt == 0) found = 1'b1;
      else step(1'b1, 1'b0, 32'd0);
    end
    chk("s3_found_104", found, 1'b1);
    step(1'b1, 1'b1, 32'h2003);
    n = 0;
    while (iwb_adr == 32'h104 && n < 20) begin
      chk("s3_drop_fvld", fvld, 1'b0);
      step(1'b1, 1'b0, 32'd0);
      n++;
    end
    chk("s3_adr_tgt", iwb_adr, 32'h2000);
    n = 0;
    while (!fvld && n < 20) begin
      step(1'b1, 1'b0, 32'd0);
      n++;
    end
    chk("s3_fvld", fvld, 1'b1);
    chk("s3_fpc", fpc, 32'h2000);

    // Redirect coincident with ack and pop, then wrap.
    do_reset();
    nwait = 0;
    repeat (3) step(1'b1, 1'b0, 32'd0);
    chk("s4_pre_fvld", fvld, 1'b1);
    step(1'b1, 1'b1, 32'h400);
    chk("s4_fvld", fvld, 1'b0);
    chk("s4_adr", iwb_adr, 32'h400);
    step(1'b1, 1'b0, 32'd0);
    chk("s4_fpc", fpc, 32'h400);
    step(1'b1, 1'b1, 32'hFFFF_FFF8);
    chk("s5_adr0", iwb_adr, 32'hFFFF_FFF8);
    step(1'b1, 1'b0, 32'd0);
    chk("s5_adr1", iwb_adr, 32'hFFFF_FFFC);
    chk("s5_fpc0", fpc, 32'hFFFF_FFF8);
    step(1'b1, 1'b0, 32'd0);
    chk("s5_adr2", iwb_adr, 32'h0000_0000);
    chk("s5_fpc1", fpc, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'd0);
    chk("s5_fpc2", fpc, 32'h0000_0000);

    // Asynchronous reset mid-transfer, late ack ignored after release.
    nwait = 3;
    step(1'b1, 1'b0, 32'd0);
    chk("s6_pre_stb", iwb_stb, 1'b1);
    #2;
    srst_n = 1'b0;
    #1;
    chk("s6_async_stb", iwb_stb, 1'b0);
    chk("s6_async_fvld", fvld, 1'b0);
    @(posedge sclk);
    #1;
    model_reset();
    srst_n  = 1'b1;
    sena    = 1'b1;
    iwb_ack = 1'b1;
    iwb_dat = 32'hDEAD_BEEF;
    @(posedge sclk);
    model_edge();
    #1;
    compare_all();
    chk("s6_restart_adr", iwb_adr, 32'h100);
    chk("s6_late_ack_fvld", fvld, 1'b0);
    n = 0;
    while (!fvld && n < 20) begin
      step(1'b1, 1'b0, 32'd0);
      n++;
    end
    chk("s6_fpc", fpc, 32'h100);

    // Randomized traffic.
    do_reset();
    for (int ph = 0; ph < 40; ph++) begin
      nwait = $urandom_range(0, 3);
      for (int c = 0; c < 60; c++) begin
        if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        else tgt = $urandom;
        step($urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0, tgt);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
